// File: rtl/injection_scheduler_pkg.sv
// Shared definitions for the injection scheduler: state encodings, LFSR taps
// and the counter widths.
package injection_scheduler_pkg;

  typedef enum logic [1:0] {
    INJ_IDLE   = 2'd0,
    INJ_INJECT = 2'd1,
    INJ_DRAIN  = 2'd2,
    INJ_DONE   = 2'd3
  } inj_state_e;

  // x^8+x^6+x^5+x^4+1, as feedback taps on bits 7,5,4,3 of a left-shifting LFSR
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned CNT_W     = 16;  // per-node packet count
  localparam int unsigned TOTAL_W   = 24;  // total packets per run
  localparam int unsigned ELAPSED_W = 32;  // cycles in INJECT+DRAIN
  localparam int unsigned QUIET_W   = 8;   // drain quiet-run counter

endpackage

// File: rtl/injection_scheduler_if.sv
// Control/status bundle of the injection scheduler.
//   master: the bench side (drives start/abort/busy/activity, observes status)
//   slave : the scheduler
interface injection_scheduler_if #(
  parameter int unsigned NUM_NODES = 9
);
  import injection_scheduler_pkg::*;

  logic                   start;
  logic                   abort;
  logic [NUM_NODES-1:0]   source_busy;
  logic [NUM_NODES-1:0]   router_active;
  logic [NUM_NODES-1:0]   send;
  logic [1:0]             state;
  logic                   done;
  logic                   timed_out;
  logic [TOTAL_W-1:0]     total_sent;
  logic [ELAPSED_W-1:0]   elapsed;

  modport master (
    output start, abort, source_busy, router_active,
    input  send, state, done, timed_out, total_sent, elapsed
  );

  modport slave (
    input  start, abort, source_busy, router_active,
    output send, state, done, timed_out, total_sent, elapsed
  );

endinterface

// File: rtl/injection_scheduler_lfsr8.sv
// 8-bit maximal-length LFSR supplying one node's random byte.
//   clk, reset (sync, active-low): reload to seed on reset
//   enable : advance one step
//   seed   : reload value; a zero seed is replaced by 8'h01 (all-zero locks up)
//   value  : current LFSR state
module lfsr8
  import injection_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] r_value;
  logic [7:0] w_load;
  logic       w_feedback;

  assign w_load     = (seed == 8'h00) ? 8'h01 : seed;
  assign w_feedback = ^(r_value & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_value <= w_load;
    end else if (enable) begin
      r_value <= {r_value[6:0], w_feedback};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/injection_scheduler.sv
// Traffic-injection sequencer: issues per-node send pulses at a programmable
// rate up to a per-node packet budget, then waits for the network to drain
// (QUIET_CYCLES consecutive cycles with no router/source activity) and flags done.
//   clk, reset (sync, active-low)
//   bus.start / bus.abort        : run control (abort wins)
//   bus.source_busy/router_active: per-node activity inputs
//   bus.send                     : one-cycle injection pulses
//   bus.state/done/timed_out     : status; total_sent, elapsed: run counters
// Optional macro INJ_SCHED_TIMEOUT_EN adds a DRAIN watchdog (DRAIN_TIMEOUT cycles).
module injection_scheduler
  import injection_scheduler_pkg::*;
#(
  parameter int unsigned NUM_NODES     = 9,
  parameter int unsigned PIR           = 255,
  parameter int unsigned PKT_BUDGET    = 64,
  parameter int unsigned QUIET_CYCLES  = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  injection_scheduler_if.slave bus
);

  // Rate threshold widened to 9 bits so PIR=255 means "always".
  localparam logic [8:0] RATE_THR = (PIR >= 255) ? 9'd256 : 9'(PIR);

  inj_state_e             r_state;
  logic [CNT_W-1:0]       r_count [NUM_NODES];
  logic [NUM_NODES-1:0]   r_holdoff;
  logic [NUM_NODES-1:0]   r_send;
  logic [QUIET_W-1:0]     r_quiet;
  logic [TOTAL_W-1:0]     r_total;
  logic [ELAPSED_W-1:0]   r_elapsed;
  logic                   r_done;
  logic                   r_timed_out;

  logic                   w_lfsr_en;
  logic [7:0]             w_rand [NUM_NODES];
  logic [NUM_NODES-1:0]   w_fire;
  logic [NUM_NODES-1:0]   w_node_done;
  logic [TOTAL_W-1:0]     w_fire_cnt;
  logic                   w_quiet_now;
  logic                   w_quiet_reached;
  logic [ELAPSED_W-1:0]   w_elapsed_nxt;

`ifdef INJ_SCHED_TIMEOUT_EN
  logic [31:0]            r_drain_cnt;
  logic                   w_drain_expired;
  assign w_drain_expired = (r_drain_cnt == 32'(DRAIN_TIMEOUT - 1));
`else
  logic [31:0]            w_unused_timeout;
  assign w_unused_timeout = 32'(DRAIN_TIMEOUT);
`endif

  assign w_lfsr_en = (r_state == INJ_INJECT);

  // Per-node random source and eligibility.
  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
    lfsr8 u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (w_lfsr_en),
      .seed   (LFSR_SEED ^ 8'(gi + 1)),
      .value  (w_rand[gi])
    );

    assign w_node_done[gi] = (r_count[gi] == CNT_W'(PKT_BUDGET));
    assign w_fire[gi]      = w_lfsr_en && !w_node_done[gi] && !bus.source_busy[gi]
                             && !r_holdoff[gi] && ({1'b0, w_rand[gi]} < RATE_THR);
  end

  // Number of nodes firing this cycle.
  always_comb begin
    w_fire_cnt = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      w_fire_cnt = w_fire_cnt + TOTAL_W'(w_fire[i]);
    end
  end

  assign w_quiet_now     = ~|(bus.router_active | bus.source_busy);
  assign w_quiet_reached = (r_quiet == QUIET_W'(QUIET_CYCLES - 1));
  assign w_elapsed_nxt   = (&r_elapsed) ? r_elapsed : r_elapsed + 1'b1;

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= INJ_IDLE;
      r_send      <= '0;
      r_holdoff   <= '0;
      r_quiet     <= '0;
      r_total     <= '0;
      r_elapsed   <= '0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) r_count[i] <= '0;
`ifdef INJ_SCHED_TIMEOUT_EN
      r_drain_cnt <= '0;
`endif
    end else if (bus.abort) begin
      // Counters are left untouched so a run can be inspected after abort.
      r_state   <= INJ_IDLE;
      r_send    <= '0;
      r_holdoff <= '0;
      r_done    <= 1'b0;
    end else begin
      r_send <= '0;
      case (r_state)
        INJ_IDLE, INJ_DONE: begin
          if (bus.start) begin
            r_state     <= INJ_INJECT;
            r_holdoff   <= '0;
            r_quiet     <= '0;
            r_total     <= '0;
            r_elapsed   <= '0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) r_count[i] <= '0;
`ifdef INJ_SCHED_TIMEOUT_EN
            r_drain_cnt <= '0;
`endif
          end
        end

        INJ_INJECT: begin
          r_elapsed <= w_elapsed_nxt;
          if (&w_node_done) begin
            r_state   <= INJ_DRAIN;
            r_quiet   <= '0;
            r_holdoff <= '0;
          end else begin
            // Hold-off masks the cycle before the source raises busy.
            r_send    <= w_fire;
            r_holdoff <= w_fire;
            r_total   <= r_total + w_fire_cnt;
            for (int i = 0; i < NUM_NODES; i++) begin
              r_count[i] <= r_count[i] + CNT_W'(w_fire[i]);
            end
          end
        end

        INJ_DRAIN: begin
          r_elapsed <= w_elapsed_nxt;
          r_quiet   <= w_quiet_now ? r_quiet + 1'b1 : '0;
          if (w_quiet_now && w_quiet_reached) begin
            r_state <= INJ_DONE;
            r_done  <= 1'b1;
          end
`ifdef INJ_SCHED_TIMEOUT_EN
          else if (w_drain_expired) begin
            r_state     <= INJ_DONE;
            r_done      <= 1'b1;
            r_timed_out <= 1'b1;
          end
          r_drain_cnt <= r_drain_cnt + 32'd1;
`endif
        end

        default: r_state <= INJ_IDLE;
      endcase
    end
  end

  assign bus.send       = r_send;
  assign bus.state      = r_state;
  assign bus.done       = r_done;
  assign bus.timed_out  = r_timed_out;
  assign bus.total_sent = r_total;
  assign bus.elapsed    = r_elapsed;

endmodule

// File: tb/tb_injection_scheduler.sv
// Bench for injection_scheduler: directed scenarios on a peak-rate instance,
// a zero-rate instance, and randomized traffic on a mid-rate instance checked
// cycle by cycle against a behavioural model.
module tb_injection_scheduler;
  import injection_scheduler_pkg::*;

  localparam int unsigned NA       = 9;
  localparam int unsigned NC       = 4;
  localparam int          C_PIR    = 100;
  localparam int          C_BUDGET = 3;
  localparam int          C_QUIET  = 5;
  localparam logic [7:0]  C_SEED   = 8'h3C;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  injection_scheduler_if #(.NUM_NODES(NA)) ifa ();
  injection_scheduler_if #(.NUM_NODES(NA)) ifb ();
  injection_scheduler_if #(.NUM_NODES(NC)) ifc ();

  injection_scheduler #(.NUM_NODES(NA), .PIR(255), .PKT_BUDGET(4), .QUIET_CYCLES(16),
                        .LFSR_SEED(8'hA5), .DRAIN_TIMEOUT(100))
    u_dut_a (.clk(clk), .reset(rst_n), .bus(ifa));

  injection_scheduler #(.NUM_NODES(NA), .PIR(0), .PKT_BUDGET(64), .QUIET_CYCLES(16),
                        .LFSR_SEED(8'hA5), .DRAIN_TIMEOUT(4096))
    u_dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

  injection_scheduler #(.NUM_NODES(NC), .PIR(C_PIR), .PKT_BUDGET(C_BUDGET),
                        .QUIET_CYCLES(C_QUIET), .LFSR_SEED(C_SEED), .DRAIN_TIMEOUT(1000000))
    u_dut_c (.clk(clk), .reset(rst_n), .bus(ifc));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  // ---------------- behavioural model of instance C ----------------
  // Every node's LFSR steps once per INJECT cycle, so all nodes share one
  // step index into their precomputed 255-entry sequences.
  int          seq [NC][255];
  int          m_state;
  int          m_count [NC];
  logic [NC-1:0] m_hold, m_send;
  int          m_quiet;
  int          m_total;
  logic [31:0] m_elapsed;
  logic        m_done;
  int          m_step;

  task automatic build_seq();
    for (int i = 0; i < NC; i++) begin
      logic [7:0] v;
      v = C_SEED ^ 8'(i + 1);
      if (v == 8'h00) v = 8'h01;
      for (int n = 0; n < 255; n++) begin
        seq[i][n] = int'(v);
        v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};  // x^8+x^6+x^5+x^4+1
      end
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hold = '0; m_send = '0; m_quiet = 0;
    m_total = 0; m_elapsed = '0; m_done = 1'b0; m_step = 0;
    for (int i = 0; i < NC; i++) m_count[i] = 0;
  endtask

  task automatic model_step(input logic r_n, input logic st, input logic ab,
                            input logic [NC-1:0] busy, input logic [NC-1:0] act);
    logic [NC-1:0] fire;
    int  pre;
    logic all_done;
    fire = '0;
    pre  = m_state;
    if (!r_n) begin
      model_reset();
      return;
    end
    if (pre == 1) m_step++;
    if (ab) begin
      m_state = 0; m_done = 1'b0; m_hold = '0; m_send = '0;
      return;
    end
    case (pre)
      0, 3: if (st) begin
        m_state = 1; m_total = 0; m_elapsed = '0; m_done = 1'b0; m_hold = '0; m_quiet = 0;
        for (int i = 0; i < NC; i++) m_count[i] = 0;
      end
      1: begin
        if (m_elapsed != 32'hFFFF_FFFF) m_elapsed = m_elapsed + 32'd1;
        all_done = 1'b1;
        for (int i = 0; i < NC; i++) if (m_count[i] != C_BUDGET) all_done = 1'b0;
        if (all_done) begin
          m_state = 2; m_quiet = 0;
        end else begin
          for (int i = 0; i < NC; i++)
            if (m_count[i] < C_BUDGET && !busy[i] && !m_hold[i] && seq[i][(m_step - 1) % 255] < C_PIR)
              fire[i] = 1'b1;
        end
        for (int i = 0; i < NC; i++) if (fire[i]) begin
          m_count[i]++;
          m_total++;
        end
        m_hold = fire;
      end
      2: begin
        if (m_elapsed != 32'hFFFF_FFFF) m_elapsed = m_elapsed + 32'd1;
        if ((busy | act) == '0) begin
          m_quiet++;
          if (m_quiet == C_QUIET) begin m_state = 3; m_done = 1'b1; end
        end else begin
          m_quiet = 0;
        end
      end
      default: ;
    endcase
    m_send = fire;
  endtask

  task automatic compare_c();
    check_eq("c_send",    64'(ifc.send),       64'(m_send));
    check_eq("c_state",   64'(ifc.state),      64'(m_state));
    check_eq("c_total",   64'(ifc.total_sent), 64'(m_total));
    check_eq("c_elapsed", 64'(ifc.elapsed),    64'(m_elapsed));
    check_eq("c_done",    64'(ifc.done),       64'(m_done));
    check_eq("c_timeout", 64'(ifc.timed_out),  64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p3;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.source_busy = '0; ifa.router_active = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.source_busy = '0; ifb.router_active = '0;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.source_busy = '0; ifc.router_active = '0;
    build_seq();
    tick(); tick();

    check_eq("rst_state",   64'(ifa.state),      64'd0);
    check_eq("rst_send",    64'(ifa.send),       64'd0);
    check_eq("rst_done",    64'(ifa.done),       64'd0);
    check_eq("rst_timeout", 64'(ifa.timed_out),  64'd0);
    check_eq("rst_total",   64'(ifa.total_sent), 64'd0);
    check_eq("rst_elapsed", 64'(ifa.elapsed),    64'd0);
    rst_n = 1'b1;
    tick();

    // Peak rate: every node pulses on cycles 1,3,5,7; 16-cycle drain.
    start_a();
    check_eq("peak_inject", 64'(ifa.state), 64'd1);
    check_eq("peak_send0",  64'(ifa.send),  64'd0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      check_eq("peak_send", 64'(ifa.send), (j % 2 == 1) ? 64'h1FF : 64'h0);
    end
    check_eq("peak_drain", 64'(ifa.state), 64'd2);
    for (int j = 0; j < 15; j++) begin
      tick();
      check_eq("peak_drain_hold", 64'(ifa.state), 64'd2);
    end
    tick();
    check_eq("peak_done_state", 64'(ifa.state),      64'd3);
    check_eq("peak_done",       64'(ifa.done),       64'd1);
    check_eq("peak_total",      64'(ifa.total_sent), 64'd36);
    check_eq("peak_elapsed",    64'(ifa.elapsed),    64'd24);

    // Busy source: node 3 blocked, others complete; release lets it finish.
    ifa.source_busy = 9'h008;
    start_a();
    for (int j = 0; j < 20; j++) begin
      tick();
      check_eq("busy_node3_quiet", 64'(ifa.send[3]), 64'd0);
    end
    check_eq("busy_still_inject", 64'(ifa.state),      64'd1);
    check_eq("busy_partial_total", 64'(ifa.total_sent), 64'd32);
    ifa.source_busy = '0;
    p3 = 0;
    for (int j = 0; j < 30 && ifa.state != 2'd2; j++) begin
      tick();
      if (ifa.send[3]) p3++;
      check_eq("busy_others_idle", 64'(ifa.send & 9'h1F7), 64'd0);
    end
    check_eq("busy_reach_drain", 64'(ifa.state),      64'd2);
    check_eq("busy_node3_pulses", 64'(p3),            64'd4);
    check_eq("busy_total",        64'(ifa.total_sent), 64'd36);
    for (int j = 0; j < 40 && ifa.state != 2'd3; j++) tick();
    check_eq("busy_done", 64'(ifa.state), 64'd3);

    // Drain restart: activity pulse at quiet count 10 restarts the quiet run.
    start_a();
    repeat (8) tick();
    check_eq("restart_drain", 64'(ifa.state), 64'd2);
    repeat (10) tick();
    ifa.router_active = 9'h020;
    tick();
    ifa.router_active = '0;
    for (int j = 0; j < 15; j++) begin
      tick();
      check_eq("restart_hold", 64'(ifa.state), 64'd2);
    end
    tick();
    check_eq("restart_done", 64'(ifa.state), 64'd3);

    // Abort mid-INJECT: IDLE next cycle, send cleared, counters held.
    start_a();
    repeat (3) tick();
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    check_eq("abort_state", 64'(ifa.state),      64'd0);
    check_eq("abort_send",  64'(ifa.send),       64'd0);
    check_eq("abort_done",  64'(ifa.done),       64'd0);
    check_eq("abort_total", 64'(ifa.total_sent), 64'd18);

    // Reset mid-DRAIN.
    start_a();
    repeat (11) tick();
    check_eq("rst2_in_drain", 64'(ifa.state), 64'd2);
    rst_n = 1'b0;
    tick();
    check_eq("rst2_state",   64'(ifa.state),      64'd0);
    check_eq("rst2_send",    64'(ifa.send),       64'd0);
    check_eq("rst2_done",    64'(ifa.done),       64'd0);
    check_eq("rst2_total",   64'(ifa.total_sent), 64'd0);
    check_eq("rst2_elapsed", 64'(ifa.elapsed),    64'd0);
    rst_n = 1'b1;
    tick();

    // Stuck router activity: watchdog fires only when built in.
    ifa.router_active = '1;
    start_a();
    repeat (8) tick();
    check_eq("wd_drain", 64'(ifa.state), 64'd2);
`ifdef INJ_SCHED_TIMEOUT_EN
    repeat (99) tick();
    check_eq("wd_pre", 64'(ifa.state), 64'd2);
    tick();
    check_eq("wd_state",   64'(ifa.state),     64'd3);
    check_eq("wd_done",    64'(ifa.done),      64'd1);
    check_eq("wd_timeout", 64'(ifa.timed_out), 64'd1);
`else
    repeat (200) tick();
    check_eq("wd_wait_state", 64'(ifa.state),     64'd2);
    check_eq("wd_no_timeout", 64'(ifa.timed_out), 64'd0);
`endif
    ifa.router_active = '0;
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    check_eq("wd_abort", 64'(ifa.state), 64'd0);

    // Zero rate: never sends, stays in INJECT.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      check_eq("zero_send", 64'(ifb.send), 64'd0);
    end
    check_eq("zero_state",   64'(ifb.state),   64'd1);
    check_eq("zero_elapsed", 64'(ifb.elapsed), 64'd1000);

    // Randomized traffic on instance C against the model.
    rst_n = 1'b0;
    tick();
    model_step(1'b0, 1'b0, 1'b0, '0, '0);
    compare_c();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r, a, s;
      logic [NC-1:0] busy, act;
      r    = ($urandom_range(0, 599) != 0);
      a    = ($urandom_range(0, 199) == 0);
      s    = ($urandom_range(0, 3) == 0);
      busy = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      act  = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
      rst_n = r;
      ifc.abort = a; ifc.start = s; ifc.source_busy = busy; ifc.router_active = act;
      tick();
      model_step(r, s, a, busy, act);
      compare_c();
    end
    rst_n = 1'b1;
    ifc.abort = 1'b0; ifc.start = 1'b0; ifc.source_busy = '0; ifc.router_active = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
